// File: rtl/cv32e41s_b_clmul_iter.sv
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR) for the bit-manipulation unit.
// Consumes BITS_PER_CYCLE bits of op_b per cycle, LSB first, into a 2*XLEN accumulator.
module cv32e41s_b_clmul_iter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned NUM_ITER = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W    = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
        BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32) ||
      (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_bits_per_cycle
    $error("BITS_PER_CYCLE must be 1/2/4/8/16/32 and divide XLEN");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [1:0] OP_CLMUL  = 2'b00;
  localparam logic [1:0] OP_CLMULH = 2'b01;
  localparam logic [1:0] OP_CLMULR = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [2*XLEN-1:0]   a_q, a_d;      // op_a pre-shifted to the weight of the next b bit
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [2*XLEN-1:0]   partial;
  logic [2*XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]     result_sel;

  // Partial product of this slice of op_b; XOR only, so no carries cross bit positions.
  always_comb begin
    partial = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) partial = partial ^ (a_q << j);
    end
    acc_nxt = acc_q ^ partial;

    unique case (op_q)
      OP_CLMUL:  result_sel = acc_nxt[XLEN-1:0];
      OP_CLMULH: result_sel = acc_nxt[2*XLEN-1:XLEN];
      OP_CLMULR: result_sel = acc_nxt[2*XLEN-2:XLEN-1];
      default:   result_sel = '0;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    // Kill wins over everything and must not load result_o on the last BUSY cycle.
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            state_d = BUSY;
            op_d    = op_i;
            a_d     = {{XLEN{1'b0}}, op_a_i};
            b_d     = op_b_i;
            acc_d   = '0;
            cnt_d   = CNT_W'(NUM_ITER - 1);
          end
        end
        BUSY: begin
          acc_d = acc_nxt;
          a_d   = a_q << BITS_PER_CYCLE;
          b_d   = b_q >> BITS_PER_CYCLE;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = result_sel;
          end
        end
        DONE: begin
          if (ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_cv32e41s_b_clmul_iter.sv
// Bench for cv32e41s_b_clmul_iter: directed vectors through a scoreboard on the default
// configuration, plus a BITS_PER_CYCLE sweep against a software carry-less reference.
module tb_cv32e41s_b_clmul_iter;

  localparam int LAT = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, kill_i, ready_i;
  logic [1:0]  op_i;
  logic [31:0] op_a_i, op_b_i;
  logic        ready_o, valid_o;
  logic [31:0] result_o;

  logic [2:0]  s_valid, s_ready_o, s_valid_o;
  logic [1:0]  s_op;
  logic [31:0] s_a, s_b;
  logic [31:0] s_result [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic valid_prev = 1'b0;
  logic hs_q       = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cv32e41s_b_clmul_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .kill_i   (kill_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    cv32e41s_b_clmul_iter #(
      .XLEN(32),
      .BITS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 8 : 32))
    ) u_sw (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (s_valid[g]),
      .ready_o  (s_ready_o[g]),
      .op_i     (s_op),
      .op_a_i   (s_a),
      .op_b_i   (s_b),
      .kill_i   (1'b0),
      .valid_o  (s_valid_o[g]),
      .ready_i  (1'b1),
      .result_o (s_result[g])
    );
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] clmul_ref(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  // Handshake seen at an edge: valid_o must be gone by the following negedge.
  always @(posedge clk) hs_q <= valid_o && ready_i && !kill_i && !rst;

  // Monitor: pop an expectation when a result appears, then hold it while valid_o stays.
  always @(negedge clk) begin
    if (valid_o && hs_q) begin
      check("valid_after_handshake", valid_o, 1'b0);
    end else if (valid_o && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", valid_o, 1'b0);
      end else begin
        cur = exp_q.pop_front();
        check("result", result_o, cur.res);
        check("latency", cyc - cur.acc, LAT);
      end
    end else if (valid_o) begin
      check("result_stable", result_o, cur.res);
    end
    valid_prev <= valid_o;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit track, output int acc);
    int n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", ready_o, 1'b1);
    valid_i = 1'b1;
    op_i    = op;
    op_a_i  = a;
    op_b_i  = b;
    acc     = cyc;
    if (track) exp_q.push_back('{res: exp, acc: acc});
    @(negedge clk);
    valid_i = 1'b0;
    op_i    = 2'($urandom);
    op_a_i  = $urandom;
    op_b_i  = $urandom;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [10] = '{
    '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
    '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
    '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555},
    '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555},
    '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA},
    '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
    '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
    '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
    '{2'b00, 32'h0000_000F, 32'h0000_00F0, 32'h0000_0550}
  };

  int sw_lat [3] = '{33, 5, 2};

  initial begin
    int acc;
    int n;
    int start;
    logic [31:0] exp;
    logic [2:0]  seen;

    rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    op_i = 2'b00; op_a_i = '0; op_b_i = '0;
    s_valid = '0; s_op = '0; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready_o, 1'b1);
    check("reset_valid", valid_o, 1'b0);
    check("reset_result", result_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic CLMUL 3x3 with ready back one cycle after the result.
    issue(2'b00, 32'h3, 32'h3, 32'h5, 1'b1, acc);
    while (cyc < acc + 10) @(negedge clk);
    check("ready_after_result", ready_o, 1'b1);

    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b1, acc);

    // Backpressure: results held, new requests ignored, and no accept on the handshake cycle.
    n = 0;
    while ((exp_q.size() != 0 || !ready_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    ready_i = 1'b0;
    issue(2'b00, 32'h0000_000F, 32'h0000_00F0, 32'h0000_0550, 1'b1, acc);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", valid_o, 1'b1);
    repeat (3) begin
      check("bp_ready_low", ready_o, 1'b0);
      valid_i = 1'b1; op_i = 2'b00; op_a_i = 32'h1; op_b_i = 32'h1;
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("bp_idle", ready_o, 1'b1);

    // Kill has priority over a request in IDLE.
    valid_i = 1'b1; kill_i = 1'b1; op_a_i = 32'h3; op_b_i = 32'h3;
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    check("kill_over_valid", ready_o, 1'b1);

    // Kill mid-operation.
    issue(2'b00, 32'h3, 32'h3, 32'h5, 1'b0, acc);
    while (cyc < acc + 4) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_ready", ready_o, 1'b1);
    check("kill_valid", valid_o, 1'b0);
    repeat (12) @(negedge clk);

    // Reset mid-operation: previous result 0x550 must be cleared.
    issue(2'b00, 32'h3, 32'h3, 32'h5, 1'b0, acc);
    while (cyc < acc + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_result", result_o, 32'h0);
    repeat (12) @(negedge clk);

    issue(2'b00, 32'h3, 32'h3, 32'h5, 1'b1, acc);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pending_results", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // BITS_PER_CYCLE sweep: 1, 8, 32 against the software reference.
    for (int t = 0; t < 4; t++) begin
      for (int op = 0; op < 3; op++) begin
        @(negedge clk);
        s_a = $urandom;
        s_b = $urandom;
        s_op = 2'(op);
        s_valid = 3'b111;
        start = cyc;
        exp = clmul_ref(s_op, s_a, s_b);
        @(negedge clk);
        s_valid = 3'b000;
        s_a = $urandom;
        s_b = $urandom;
        seen = 3'b000;
        for (int k = 0; k < 40; k++) begin
          if (seen == 3'b111) break;
          for (int g = 0; g < 3; g++) begin
            if (s_valid_o[g] && !seen[g]) begin
              check("sweep_result", s_result[g], exp);
              check("sweep_latency", cyc - start, sw_lat[g]);
              seen[g] = 1'b1;
            end
          end
          @(negedge clk);
        end
        check("sweep_done", seen, 3'b111);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
